// File: rtl/decode_rr_stage_if.sv
// Bus bundle for the decode/register-read stage: upstream instruction
// handshake, writeback feedback, flush, and the downstream output entry.
// The stage itself connects through the slave modport; whatever drives
// the stage (previous pipe stage, writeback, test environment) uses master.
interface decode_rr_stage_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int CCW   = 3
);
  // upstream instruction side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_npc;
  logic [WIDTH-1:0] in_ir;
  logic [AW-1:0]    in_src_a;
  logic [AW-1:0]    in_src_b;
  logic             in_use_a;
  logic             in_use_b;
  logic [AW-1:0]    in_dest;
  logic             in_wr_reg;
  logic             in_use_cc;
  logic             in_wr_cc;
  // pipeline control
  logic             flush;
  // writeback feedback
  logic             wb_reg_en;
  logic [AW-1:0]    wb_reg_dest;
  logic [WIDTH-1:0] wb_reg_data;
  logic             wb_cc_en;
  logic [CCW-1:0]   wb_cc_data;
  // downstream output entry
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_npc;
  logic [WIDTH-1:0] out_ir;
  logic [WIDTH-1:0] out_sr1;
  logic [WIDTH-1:0] out_sr2;
  logic [AW-1:0]    out_dr;
  logic             out_wr_reg;
  logic             out_wr_cc;
  logic [CCW-1:0]   out_cc;

  modport master (
    output in_valid, in_npc, in_ir, in_src_a, in_src_b, in_use_a, in_use_b,
           in_dest, in_wr_reg, in_use_cc, in_wr_cc, flush,
           wb_reg_en, wb_reg_dest, wb_reg_data, wb_cc_en, wb_cc_data, out_ready,
    input  in_ready, out_valid, out_npc, out_ir, out_sr1, out_sr2, out_dr,
           out_wr_reg, out_wr_cc, out_cc
  );

  modport slave (
    input  in_valid, in_npc, in_ir, in_src_a, in_src_b, in_use_a, in_use_b,
           in_dest, in_wr_reg, in_use_cc, in_wr_cc, flush,
           wb_reg_en, wb_reg_dest, wb_reg_data, wb_cc_en, wb_cc_data, out_ready,
    output in_ready, out_valid, out_npc, out_ir, out_sr1, out_sr2, out_dr,
           out_wr_reg, out_wr_cc, out_cc
  );
endinterface

// File: rtl/decode_rr_stage.sv
// Decode/register-read stage in front of execute. Holds the architectural
// register file and condition code, bypasses same-cycle writeback into the
// operand read, tracks outstanding writers with a busy-bit scoreboard to
// stall RAW/WAW hazards, and presents one valid/ready output entry that a
// flush can squash (returning its scoreboard reservations).
module decode_rr_stage #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int CCW      = 3
) (
  input logic              clk,
  input logic              reset_n,
  decode_rr_stage_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  // architectural state
  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [CCW-1:0]      cc_q, cc_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                sb_cc_q, sb_cc_d;

  // output entry
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_npc_q, out_npc_d;
  logic [WIDTH-1:0]    out_ir_q, out_ir_d;
  logic [WIDTH-1:0]    out_sr1_q, out_sr1_d;
  logic [WIDTH-1:0]    out_sr2_q, out_sr2_d;
  logic [AW-1:0]       out_dr_q, out_dr_d;
  logic                out_wr_reg_q, out_wr_reg_d;
  logic                out_wr_cc_q, out_wr_cc_d;
  logic [CCW-1:0]      out_cc_q, out_cc_d;

  // combinational helpers
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] busy_eff;
  logic                cc_busy_eff;
  logic                hazard;
  logic                in_ready;
  logic                fire;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [CCW-1:0]      cc_rd;

  // Hazard detection: a writer completing this cycle no longer blocks readers.
  always_comb begin
    wb_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.wb_reg_en && (bus.wb_reg_dest == AW'(r))) begin
        wb_hit[r] = 1'b1;
      end else begin
        wb_hit[r] = 1'b0;
      end
    end
    busy_eff    = sb_q & ~wb_hit;
    cc_busy_eff = sb_cc_q & ~bus.wb_cc_en;
    hazard      = bus.in_valid &
                  ((bus.in_use_a  & busy_eff[bus.in_src_a]) |
                   (bus.in_use_b  & busy_eff[bus.in_src_b]) |
                   (bus.in_wr_reg & busy_eff[bus.in_dest])  |
                   ((bus.in_use_cc | bus.in_wr_cc) & cc_busy_eff));
    in_ready    = (~out_valid_q | bus.out_ready) & ~hazard & ~bus.flush;
    fire        = bus.in_valid & in_ready;
  end

  // Operand and CC read, forwarding the value being written back this cycle.
  always_comb begin
    if (bus.wb_reg_en && (bus.wb_reg_dest == bus.in_src_a)) begin
      op_a = bus.wb_reg_data;
    end else begin
      op_a = regs_q[bus.in_src_a];
    end
    if (bus.wb_reg_en && (bus.wb_reg_dest == bus.in_src_b)) begin
      op_b = bus.wb_reg_data;
    end else begin
      op_b = regs_q[bus.in_src_b];
    end
    if (bus.wb_cc_en) begin
      cc_rd = bus.wb_cc_data;
    end else begin
      cc_rd = cc_q;
    end
  end

  // Next architectural state: writeback, then flush release, then issue
  // reservations last so a same-cycle set wins over a clear.
  always_comb begin
    regs_d  = regs_q;
    cc_d    = cc_q;
    sb_d    = sb_q;
    sb_cc_d = sb_cc_q;
    if (bus.wb_reg_en) begin
      regs_d[bus.wb_reg_dest] = bus.wb_reg_data;
    end else begin
      regs_d = regs_q;
    end
    if (bus.wb_cc_en) begin
      cc_d    = bus.wb_cc_data;
      sb_cc_d = 1'b0;
    end else begin
      cc_d    = cc_q;
    end
    sb_d = sb_d & ~wb_hit;
    if (bus.flush && out_valid_q) begin
      if (out_wr_reg_q) begin
        sb_d[out_dr_q] = 1'b0;
      end else begin
        sb_d = sb_d;
      end
      if (out_wr_cc_q) begin
        sb_cc_d = 1'b0;
      end else begin
        sb_cc_d = sb_cc_d;
      end
    end else begin
      sb_d = sb_d;
    end
    if (fire) begin
      if (bus.in_wr_reg) begin
        sb_d[bus.in_dest] = 1'b1;
      end else begin
        sb_d = sb_d;
      end
      if (bus.in_wr_cc) begin
        sb_cc_d = 1'b1;
      end else begin
        sb_cc_d = sb_cc_d;
      end
    end else begin
      sb_d = sb_d;
    end
  end

  // Output entry: load on accept, drop on release or flush, otherwise hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_npc_d    = out_npc_q;
    out_ir_d     = out_ir_q;
    out_sr1_d    = out_sr1_q;
    out_sr2_d    = out_sr2_q;
    out_dr_d     = out_dr_q;
    out_wr_reg_d = out_wr_reg_q;
    out_wr_cc_d  = out_wr_cc_q;
    out_cc_d     = out_cc_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d  = 1'b1;
      out_npc_d    = bus.in_npc;
      out_ir_d     = bus.in_ir;
      out_sr1_d    = op_a;
      out_sr2_d    = op_b;
      out_dr_d     = bus.in_dest;
      out_wr_reg_d = bus.in_wr_reg;
      out_wr_cc_d  = bus.in_wr_cc;
      out_cc_d     = cc_rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      cc_q         <= '0;
      sb_q         <= '0;
      sb_cc_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_npc_q    <= '0;
      out_ir_q     <= '0;
      out_sr1_q    <= '0;
      out_sr2_q    <= '0;
      out_dr_q     <= '0;
      out_wr_reg_q <= 1'b0;
      out_wr_cc_q  <= 1'b0;
      out_cc_q     <= '0;
    end else begin
      regs_q       <= regs_d;
      cc_q         <= cc_d;
      sb_q         <= sb_d;
      sb_cc_q      <= sb_cc_d;
      out_valid_q  <= out_valid_d;
      out_npc_q    <= out_npc_d;
      out_ir_q     <= out_ir_d;
      out_sr1_q    <= out_sr1_d;
      out_sr2_q    <= out_sr2_d;
      out_dr_q     <= out_dr_d;
      out_wr_reg_q <= out_wr_reg_d;
      out_wr_cc_q  <= out_wr_cc_d;
      out_cc_q     <= out_cc_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_npc    = out_npc_q;
  assign bus.out_ir     = out_ir_q;
  assign bus.out_sr1    = out_sr1_q;
  assign bus.out_sr2    = out_sr2_q;
  assign bus.out_dr     = out_dr_q;
  assign bus.out_wr_reg = out_wr_reg_q;
  assign bus.out_wr_cc  = out_wr_cc_q;
  assign bus.out_cc     = out_cc_q;

endmodule

// File: doc/decode_rr_stage.md
Name: decode_rr_stage

Overview:
- Parametrised decode/register-read stage for the pipelined core, in front of execute.
- Combines a NUM_REGS x WIDTH register file, condition-code register, writeback bypass, a busy-bit scoreboard for RAW/WAW hazards, and a valid/ready output pipeline register with flush.
- Upstream control decode supplies register indices and use flags.
- Writeback feeds results and the condition code back into this stage.

Parameters:
- WIDTH, 16: data/instruction/PC width.
- NUM_REGS, 8: architectural register count (power of two, >=2).
- AW, $clog2(NUM_REGS): register index width (derived; do not override).
- CCW, 3: condition-code width (nzp).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_npc  in  WIDTH  next PC.
- in_ir  in  WIDTH  instruction word, passed through.
- in_src_a  in  AW  source A index.
- in_src_b  in  AW  source B index.
- in_use_a  in  1  instruction reads source A.
- in_use_b  in  1  instruction reads source B.
- in_dest  in  AW  destination index.
- in_wr_reg  in  1  instruction writes in_dest.
- in_use_cc  in  1  instruction reads CC.
- in_wr_cc  in  1  instruction writes CC.
- flush  in  1  squash the output entry and block acceptance this cycle.
- wb_reg_en  in  1  register writeback.
- wb_reg_dest  in  AW  writeback index.
- wb_reg_data  in  WIDTH  writeback data.
- wb_cc_en  in  1  CC writeback.
- wb_cc_data  in  CCW  CC writeback value.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_npc, out_ir  out  WIDTH  registered copies of the inputs.
- out_sr1, out_sr2  out  WIDTH  operand values.
- out_dr  out  AW  registered destination index.
- out_wr_reg, out_wr_cc  out  1  registered write flags.
- out_cc  out  CCW  CC value captured with the instruction.

Behaviour:
- **Reset** (reset_n=0 at an edge): out_valid=0; all other out_* = 0; all registers = 0; CC = 0; all scoreboard bits = 0. Reset overrides writeback and flush.
- **Effective busy:** busy_eff[r] = sb[r] & ~(wb_reg_en & wb_reg_dest==r). cc_busy_eff = sb_cc & ~wb_cc_en.
- **Hazard:** in_valid & (in_use_a&busy_eff[src_a] | in_use_b&busy_eff[src_b] | in_wr_reg&busy_eff[dest] | (in_use_cc|in_wr_cc)&cc_busy_eff).
- **in_ready** = (~out_valid | out_ready) & ~hazard & ~flush. This is combinational; no dependence on in_valid except through hazard.
- **fire** = in_valid & in_ready. On fire the output register captures all fields in the same cycle (1-cycle latency).
- **Operand read with bypass:** if wb_reg_en & wb_reg_dest==src, the operand is wb_reg_data, otherwise the register file value. The CC read is bypassed the same way from wb_cc_data.
- **Scoreboard on fire:** in_wr_reg sets sb[in_dest]; in_wr_cc sets sb_cc. A writeback clear and a fire set of the same bit in the same cycle leave the bit set.
- **Writeback:** wb_reg_en writes the register file and clears sb[wb_reg_dest]; wb_cc_en writes CC and clears sb_cc. Writeback is performed even when flush=1.
- **Output register:** if fire, load and set out_valid=1. Else if out_ready, out_valid=0. Else hold every field stable. Accept-and-release in the same cycle is allowed (full throughput).
- **Flush:**
  - out_valid=0 next cycle; no acceptance this cycle.
  - If the squashed entry was valid, it releases its scoreboard bits: out_wr_reg clears sb[out_dr], out_wr_cc clears sb_cc.
  - Flush is raised only when all older writers have already passed writeback or will still write back. Squashed entries never write back.
- out_* data is don't-care-free: it holds its last captured value while out_valid=0.

Test Plan:
- **Reset:** reset_n=0 with in_valid=1, wb_reg_en=1 -> out_valid=0, sb clear, register read of any index returns 0x0000.
- **RAW stall:** issue ADD R3 (wr_reg, dest=3), out_ready=1. Next instruction uses src_a=3 -> in_ready=0 until wb_reg_en dest=3 data=0x1234. In that cycle in_ready=1 and out_sr1=0x1234 next cycle.
- **Back-to-back:** 4 independent instructions on consecutive cycles with out_ready=1 -> in_ready stays 1; out_valid high 4 cycles, with fields in order.
- **Backpressure:** out_ready=0 for 3 cycles -> in_ready=0 and out_* held bit-stable; on out_ready=1, the next entry loads in the same cycle.
- **CC:** BR (use_cc) behind an instruction with wr_cc=1 stalls. wb_cc_en with 3'b010 releases it -> out_cc=3'b010.
- **Flush:** out entry valid with wr_reg dest=5, flush=1 -> out_valid=0 and sb[5] cleared; an instruction reading R5 is accepted next cycle with no stall.
